pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall scheduler for the five-stage xgriscv pipeline. Sits beside the datapath and sequences it:
- detects load-use hazards in ID;
- squashes wrong-path instructions when a branch or jump resolves in EX;
- freezes the whole pipeline while a slow data memory access is outstanding in MEM.

It drives the datapath's stall and flush inputs, replacing its hard-wired zero hazard signal. It also keeps saturating performance counters and a sticky memory-timeout error.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum MEMWAIT cycles before error; must be in 1..2^TW-1.
- TW, 8: width of the wait counter.
- CW, 16: width of each performance counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- rs1D, rs2D  in  5  source register indices of the instruction in ID
- use_rs1D, use_rs2D  in  1  the ID instruction actually reads rs1 / rs2
- rdE  in  5  destination register of the EX instruction
- regwriteE, memtoregE  in  1  EX instruction writes a register / is a load
- pcsrcE  in  1  taken branch or jump resolved in EX
- mem_reqM  in  1  load or store present in MEM
- mem_readyM  in  1  data memory completes this cycle
- stallF, stallD, stallE, stallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM registers
- flushD, flushE, flushW  out  1  clear the IF-ID / ID-EX / MEM-WB registers at the next edge
- mem_err  out  1  sticky memory timeout
- stall_cnt, flush_cnt  out  CW  saturating counters of stall cycles and redirect events

## Operation
- loaduse = memtoregE & regwriteE & (rdE≠0) & ((use_rs1D & rs1D==rdE) | (use_rs2D & rs2D==rdE)).
- memhold = mem_reqM & ~mem_readyM.
- States: RUN, MEMWAIT, ERROR.
- FSM registers: state, wait_cnt[TW].
- The stall/flush outputs are combinational from the state and the current inputs.

RUN, first matching rule applies:
1. memhold: stallF/D/E/M=1, flushW=1. Next state MEMWAIT, wait_cnt←1.
2. pcsrcE: flushD=1, flushE=1, flush_cnt++. No stall; the load-use check is ignored because the ID instruction is wrong-path.
3. loaduse: stallF=1, stallD=1, flushE=1 (one bubble into EX).
4. Otherwise: all outputs 0.

MEMWAIT:
- If mem_readyM: evaluate rules 2–4 of RUN this cycle (release cycle), next state RUN, wait_cnt←0. A redirect deferred behind the stall is therefore taken exactly once, on release.
- Else if wait_cnt==MEM_TIMEOUT: next state ERROR, mem_err←1; stalls as in rule 1.
- Else: stalls as in rule 1, wait_cnt++.

ERROR:
- stallF/D/E/M=1 and flushW=1 permanently.
- mem_err stays 1; only reset leaves this state.

Counters:
- stall_cnt increments in every cycle with stallF=1.
- flush_cnt increments once per cycle with flushD=1 caused by pcsrcE.
- Both saturate at 2^CW−1 (no wrap).

## Timing
- Reset (synchronous): state=RUN, wait_cnt=0, mem_err=0, counters=0.
- Every stall/flush output is 0 in any cycle where reset=1, regardless of other inputs.
- Load-use costs exactly one bubble:
  - the hazard is seen in cycle n;
  - in cycle n+1 the load is in MEM, EX holds a bubble, and loaduse=0.
- A redirect costs 2 cycles: flushes are asserted in the same cycle pcsrcE=1.
- Memory wait: stalls are asserted in every cycle where mem_readyM=0 and are released in the cycle where mem_readyM=1. Zero added latency when the memory is ready in the first cycle.
- Simultaneous pcsrcE and memhold: the memory stall wins and the redirect is applied in the release cycle.
- rdE=0 never produces a hazard.
- Timeout: the transition to ERROR happens at the edge that ends the MEM_TIMEOUT-th consecutive wait cycle.
- Reset asserted mid-MEMWAIT or in ERROR returns to RUN at the next edge.

## Structure
- State encodings (RUN=2'd0, MEMWAIT=2'd1, ERROR=2'd2) and the default MEM_TIMEOUT go in xgriscv_defines.v.
- Sub-module loaduse_detect: purely combinational compare, producing loaduse.
- The top module holds the FSM, the wait counter, output decode and counters.
- The datapath takes stallF/D/E/M as enables on pcenr and the stage registers, and flushD/E/W as the floprc clear inputs. Each flush is ORed into the existing clear:
  - flushD and flushE with the datapath's pcsrc;
  - flushW replaces the current constant-0 MEM-WB clear.

## Test plan
- Load-use: lw x5 in EX, add x6,x5,x1 in ID (use_rs1D=1, rs1D=5, rdE=5) → stallF=stallD=flushE=1 for exactly 1 cycle; stall_cnt=1.
- Branch: pcsrcE=1 with loaduse also true → flushD=flushE=1, stallF=0; flush_cnt=1.
- Memory wait: mem_reqM=1, mem_readyM=0 for 3 cycles then 1 → all four stalls and flushW high for 3 cycles, low on the 4th; state back to RUN; stall_cnt=3.
- Deferred redirect: pcsrcE=1 held during a 2-cycle memory wait → no flushD during the wait; flushD=flushE=1 on the release cycle only; flush_cnt=1.
- Timeout with MEM_TIMEOUT=4: mem_readyM held 0 → mem_err=1 after the 4th wait cycle, stalls stay high; reset → mem_err=0, outputs 0, state RUN.
- Saturation with CW=4: 20 consecutive stall cycles → stall_cnt=15 and holds; rdE=0 with rs1D=0 → no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the xgriscv hazard/stall scheduler.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StError   = 2'd2
    } state_e;

    localparam int unsigned MemTimeoutDefault = 255;
    localparam int unsigned RegIdxW           = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_loaduse_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX load destination.
module loaduse_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [RegIdxW-1:0] rs1D_i,
    input  logic [RegIdxW-1:0] rs2D_i,
    input  logic               use_rs1D_i,
    input  logic               use_rs2D_i,
    input  logic [RegIdxW-1:0] rdE_i,
    input  logic               regwriteE_i,
    input  logic               memtoregE_i,
    output logic               loaduse_o
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1   = use_rs1D_i && (rs1D_i == rdE_i);
    assign hit_rs2   = use_rs2D_i && (rs2D_i == rdE_i);
    // x0 is never really written, so a load to it cannot create a dependency.
    assign loaduse_o = memtoregE_i && regwriteE_i && (rdE_i != '0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, redirect and slow-memory freeze,
// plus saturating stall/redirect counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
    parameter int unsigned TW          = 8,
    parameter int unsigned CW          = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [RegIdxW-1:0] rs1D_i,
    input  logic [RegIdxW-1:0] rs2D_i,
    input  logic               use_rs1D_i,
    input  logic               use_rs2D_i,
    input  logic [RegIdxW-1:0] rdE_i,
    input  logic               regwriteE_i,
    input  logic               memtoregE_i,
    input  logic               pcsrcE_i,
    input  logic               mem_reqM_i,
    input  logic               mem_readyM_i,
    output logic               stallF_o,
    output logic               stallD_o,
    output logic               stallE_o,
    output logic               stallM_o,
    output logic               flushD_o,
    output logic               flushE_o,
    output logic               flushW_o,
    output logic               mem_err_o,
    output logic [CW-1:0]      stall_cnt_o,
    output logic [CW-1:0]      flush_cnt_o
);

    logic          loaduse;
    logic          memhold;
    logic          resolve;
    state_e        state_q, state_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_err_q, mem_err_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    loaduse_detect u_loaduse_detect (
        .rs1D_i      (rs1D_i),
        .rs2D_i      (rs2D_i),
        .use_rs1D_i  (use_rs1D_i),
        .use_rs2D_i  (use_rs2D_i),
        .rdE_i       (rdE_i),
        .regwriteE_i (regwriteE_i),
        .memtoregE_i (memtoregE_i),
        .loaduse_o   (loaduse)
    );

    assign memhold = mem_reqM_i && !mem_readyM_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            StRun: begin
                if (memhold) begin
                    state_d    = StMemWait;
                    wait_cnt_d = TW'(1);
                end
            end
            StMemWait: begin
                if (mem_readyM_i) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TW'(MEM_TIMEOUT)) begin
                    state_d   = StError;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StError: begin
                mem_err_d = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        stallF_o = 1'b0;
        stallD_o = 1'b0;
        stallE_o = 1'b0;
        stallM_o = 1'b0;
        flushD_o = 1'b0;
        flushE_o = 1'b0;
        flushW_o = 1'b0;
        // resolve: the pipeline may advance this cycle, so redirect/load-use rules apply.
        unique case (state_q)
            StRun:     resolve = !memhold;
            StMemWait: resolve = mem_readyM_i;
            default:   resolve = 1'b0;
        endcase
        if (!reset_i) begin
            if (!resolve) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                stallE_o = 1'b1;
                stallM_o = 1'b1;
                flushW_o = 1'b1;
            end else if (pcsrcE_i) begin
                flushD_o = 1'b1;
                flushE_o = 1'b1;
            end else if (loaduse) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                flushE_o = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stallF_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flushD_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err_o   = mem_err_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned Timeout = 4;
    localparam int unsigned CntW    = 4;
    localparam int          CntMax  = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      rs1D, rs2D, rdE;
    logic            use_rs1D, use_rs2D, regwriteE, memtoregE, pcsrcE, mem_reqM, mem_readyM;
    logic            stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    // Model: pipeline is "frozen in a memory wait" for `waited` cycles, or dead after a timeout.
    bit m_waiting;
    bit m_dead;
    int m_waited;
    int m_stalls;
    int m_flushes;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (Timeout),
        .TW          (8),
        .CW          (CntW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .rs1D_i       (rs1D),
        .rs2D_i       (rs2D),
        .use_rs1D_i   (use_rs1D),
        .use_rs2D_i   (use_rs2D),
        .rdE_i        (rdE),
        .regwriteE_i  (regwriteE),
        .memtoregE_i  (memtoregE),
        .pcsrcE_i     (pcsrcE),
        .mem_reqM_i   (mem_reqM),
        .mem_readyM_i (mem_readyM),
        .stallF_o     (stallF),
        .stallD_o     (stallD),
        .stallE_o     (stallE),
        .stallM_o     (stallM),
        .flushD_o     (flushD),
        .flushE_o     (flushE),
        .flushW_o     (flushW),
        .mem_err_o    (mem_err),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; rs1D = 5'd0; rs2D = 5'd0; rdE = 5'd0;
        use_rs1D = 1'b0; use_rs2D = 1'b0; regwriteE = 1'b0; memtoregE = 1'b0;
        pcsrcE = 1'b0; mem_reqM = 1'b0; mem_readyM = 1'b1;
    endtask

    // Check outputs mid-cycle, then advance the model across the clock edge.
    task automatic cycle();
        bit hazard, frozen;
        bit [6:0] exp_ctl;
        #3;
        hazard = memtoregE && regwriteE && rdE != 0 &&
                 ((use_rs1D && rs1D == rdE) || (use_rs2D && rs2D == rdE));
        frozen = m_dead || (m_waiting && !mem_readyM) || (!m_waiting && mem_reqM && !mem_readyM);
        // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
        if (reset)       exp_ctl = 7'b0000000;
        else if (frozen) exp_ctl = 7'b1111001;
        else if (pcsrcE) exp_ctl = 7'b0000110;
        else if (hazard) exp_ctl = 7'b1100010;
        else             exp_ctl = 7'b0000000;
        check("ctrl", int'({stallF, stallD, stallE, stallM, flushD, flushE, flushW}),
              int'(exp_ctl));
        check("stall_cnt", int'(stall_cnt), m_stalls);
        check("flush_cnt", int'(flush_cnt), m_flushes);
        check("mem_err", int'(mem_err), int'(m_dead));
        @(posedge clk);
        if (reset) begin
            m_waiting = 0; m_dead = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (exp_ctl[6]) m_stalls = (m_stalls < CntMax) ? m_stalls + 1 : CntMax;
            if (exp_ctl[2]) m_flushes = (m_flushes < CntMax) ? m_flushes + 1 : CntMax;
            if (m_dead) begin
            end else if (m_waiting) begin
                if (mem_readyM) begin
                    m_waiting = 0; m_waited = 0;
                end else if (m_waited == Timeout) begin
                    m_dead = 1;
                end else begin
                    m_waited++;
                end
            end else if (mem_reqM && !mem_readyM) begin
                m_waiting = 1; m_waited = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_waiting = 0; m_dead = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;

        // Reset masks a hazard that is present on the inputs.
        reset = 1'b1; use_rs1D = 1'b1; rs1D = 5'd5; rdE = 5'd5; regwriteE = 1'b1;
        memtoregE = 1'b1; mem_reqM = 1'b1; mem_readyM = 1'b0; pcsrcE = 1'b1;
        cycle();

        // Load-use: one bubble, then the load has moved on.
        idle(); use_rs1D = 1'b1; rs1D = 5'd5; rdE = 5'd5; regwriteE = 1'b1; memtoregE = 1'b1;
        cycle();
        idle();
        cycle();
        check("loaduse_stall_cnt", int'(stall_cnt), 1);

        // Branch overrides a simultaneous load-use.
        use_rs2D = 1'b1; rs2D = 5'd7; rdE = 5'd7; regwriteE = 1'b1; memtoregE = 1'b1;
        pcsrcE = 1'b1;
        cycle();
        idle();
        cycle();
        check("branch_flush_cnt", int'(flush_cnt), 1);

        // rdE = 0 never hazards.
        use_rs1D = 1'b1; rs1D = 5'd0; rdE = 5'd0; regwriteE = 1'b1; memtoregE = 1'b1;
        cycle();

        // Memory wait of 3 cycles then release.
        do_reset();
        idle(); mem_reqM = 1'b1; mem_readyM = 1'b0;
        repeat (3) cycle();
        mem_readyM = 1'b1;
        cycle();
        idle();
        cycle();
        check("memwait_stall_cnt", int'(stall_cnt), 3);

        // Ready in the first cycle costs nothing.
        mem_reqM = 1'b1; mem_readyM = 1'b1;
        cycle();

        // Redirect held behind a 2-cycle memory wait is taken once on release.
        do_reset();
        idle(); pcsrcE = 1'b1; mem_reqM = 1'b1; mem_readyM = 1'b0;
        repeat (2) cycle();
        mem_readyM = 1'b1;
        cycle();
        idle();
        cycle();
        check("deferred_flush_cnt", int'(flush_cnt), 1);

        // Timeout, sticky error, then reset recovers.
        idle(); mem_reqM = 1'b1; mem_readyM = 1'b0;
        repeat (Timeout + 3) cycle();
        check("timeout_err", int'(mem_err), 1);
        mem_readyM = 1'b1; mem_reqM = 1'b0;
        cycle();
        do_reset();
        idle();
        cycle();

        // Saturation of the stall counter.
        mem_reqM = 1'b1; mem_readyM = 1'b0;
        repeat (3) cycle();
        mem_readyM = 1'b1;
        cycle();
        idle(); use_rs1D = 1'b1; rs1D = 5'd3; rdE = 5'd3; regwriteE = 1'b1; memtoregE = 1'b1;
        repeat (20) cycle();
        check("stall_sat", int'(stall_cnt), CntMax);

        // Randomized traffic with small register indices to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(99) < 2);
            rs1D       = 5'($urandom_range(3));
            rs2D       = 5'($urandom_range(3));
            rdE        = 5'($urandom_range(3));
            use_rs1D   = 1'($urandom_range(1));
            use_rs2D   = 1'($urandom_range(1));
            regwriteE  = ($urandom_range(99) < 80);
            memtoregE  = ($urandom_range(99) < 50);
            pcsrcE     = ($urandom_range(99) < 20);
            mem_reqM   = ($urandom_range(99) < 35);
            mem_readyM = ($urandom_range(99) < 55);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
